// File: rtl/accum_4bit_pkg.sv
// Shared definitions for the 4-bit frame accumulator: widths, FSM state
// encodings and the end-of-frame test used by the control logic.
package accum_4bit_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // True when the operand being accepted now is the last one of the frame.
    function automatic logic last_operand(input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] count);
        return (cnt + 4'd1) == count;
    endfunction

endpackage

// File: rtl/full_adder_4bit.sv
// Combinational 4-bit adder with carry-in and carry-out; the datapath of
// the accumulator.
module full_adder_4bit
    import accum_4bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};

endmodule

// File: rtl/accum_4bit.sv
// Frame accumulator: sums COUNT operands through one full_adder_4bit and
// presents the wrapped sum plus a sticky carry over a valid/ready handshake.
module accum_4bit
    import accum_4bit_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inA,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outS,
    output logic              cout,
    output logic              busy
);

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

    logic [1:0]        state_r;
    logic [DATA_W-1:0] acc_r;
    logic              ovf_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] sum_s;
    logic              carry_s;
    logic              accept_s;

    full_adder_4bit u_adder (
        .a    (acc_r),
        .b    (inA),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (carry_s)
    );

    // Handshake flags come from the state register only.
    assign in_ready  = (state_r == ST_IDLE) || (state_r == ST_ACCUM);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_ACCUM) || (state_r == ST_DONE);
    assign accept_s  = in_valid && in_ready;
    assign outS      = acc_r;
    assign cout      = ovf_r;

    // Frame FSM with the running sum, sticky carry and operand counter.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_r <= ST_IDLE;
            acc_r   <= {DATA_W{1'b0}};
            ovf_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r   <= sum_s;
                        ovf_r   <= carry_s;
                        cnt_r   <= 4'd1;
                        state_r <= (COUNT_C == 4'd1) ? ST_DONE : ST_ACCUM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        ovf_r <= ovf_r | carry_s;
                        cnt_r <= cnt_r + 4'd1;
                        state_r <= last_operand(cnt_r, COUNT_C) ? ST_DONE : ST_ACCUM;
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                        acc_r   <= {DATA_W{1'b0}};
                        ovf_r   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    acc_r   <= {DATA_W{1'b0}};
                    ovf_r   <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_4bit.sv
// Directed bench for accum_4bit (COUNT=4 and COUNT=1 instances) checked
// every cycle against a frame-level model plus hand-computed results.
module tb_accum_4bit;

    logic       clk = 1'b0;
    logic       rst_n, clear, out_ready;
    logic       iv   [2];
    logic [3:0] ia   [2];
    logic       rdy  [2];
    logic       ov   [2];
    logic [3:0] os   [2];
    logic       co   [2];
    logic       bz   [2];

    int n_cmp = 0;
    int n_err = 0;

    // Model: operands accepted so far and their plain integer total.
    int m_n   [2] = '{0, 0};
    int m_tot [2] = '{0, 0};
    int frame_len [2] = '{4, 1};

    always #5 clk = ~clk;

    accum_4bit #(.COUNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .inA(ia[0]), .clear(clear), .out_valid(ov[0]), .out_ready(out_ready),
        .outS(os[0]), .cout(co[0]), .busy(bz[0])
    );

    accum_4bit #(.COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .inA(ia[1]), .clear(clear), .out_valid(ov[1]), .out_ready(out_ready),
        .outS(os[1]), .cout(co[1]), .busy(bz[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame completes once frame_len operands are in;
    // the sticky carry is set exactly when the true total reached 16.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clear) begin
                m_n[k]   <= 0;
                m_tot[k] <= 0;
            end else if (m_n[k] == frame_len[k]) begin
                if (out_ready) begin
                    m_n[k]   <= 0;
                    m_tot[k] <= 0;
                end
            end else if (iv[k]) begin
                m_n[k]   <= m_n[k] + 1;
                m_tot[k] <= m_tot[k] + int'(ia[k]);
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("in_ready[%0d]", k), int'(rdy[k]), int'(m_n[k] != frame_len[k]));
            check($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(m_n[k] == frame_len[k]));
            check($sformatf("busy[%0d]", k), int'(bz[k]), int'(m_n[k] != 0));
            if (m_n[k] == frame_len[k]) begin
                check($sformatf("outS[%0d]", k), int'(os[k]), m_tot[k] % 16);
                check($sformatf("cout[%0d]", k), int'(co[k]), int'(m_tot[k] >= 16));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        iv[0] = 1'b1;
        ia[0] = v;
        step();
        iv[0] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
        iv[0] = 1'b0; iv[1] = 1'b0; ia[0] = 4'd0; ia[1] = 4'd0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_in_ready", int'(rdy[0]), 1);
        check("reset_out_valid", int'(ov[0]), 0);
        check("reset_outS", int'(os[0]), 0);
        check("reset_cout", int'(co[0]), 0);
        check("reset_busy", int'(bz[0]), 0);

        // Basic frame 1+2+3+4.
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        check("basic_valid", int'(ov[0]), 1);
        check("basic_outS", int'(os[0]), 10);
        check("basic_cout", int'(co[0]), 0);
        step();
        check("basic_after_valid", int'(ov[0]), 0);
        check("basic_after_ready", int'(rdy[0]), 1);

        // Overflow: carry from 15+15 must survive later adds.
        send(4'd15); send(4'd15); send(4'd1); send(4'd0);
        check("ovf_outS", int'(os[0]), 15);
        check("ovf_cout", int'(co[0]), 1);
        step();

        // Gaps between operands, then backpressure with a stray operand offered.
        send(4'd5); step(); step();
        send(4'd0); step(); step();
        send(4'd0); step(); step();
        out_ready = 1'b0;
        send(4'd7);
        iv[0] = 1'b1; ia[0] = 4'd3;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", int'(ov[0]), 1);
            check("bp_outS", int'(os[0]), 12);
            check("bp_cout", int'(co[0]), 0);
            check("bp_in_ready", int'(rdy[0]), 0);
            step();
        end
        iv[0] = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_released", int'(ov[0]), 0);
        check("bp_idle", int'(bz[0]), 0);

        // Clear with the third operand valid drops it.
        send(4'd1); send(4'd1);
        iv[0] = 1'b1; ia[0] = 4'd6; clear = 1'b1;
        step();
        iv[0] = 1'b0; clear = 1'b0;
        check("clear_busy", int'(bz[0]), 0);
        check("clear_ready", int'(rdy[0]), 1);
        send(4'd2); send(4'd2); send(4'd2); send(4'd2);
        check("clear_next_outS", int'(os[0]), 8);
        check("clear_next_cout", int'(co[0]), 0);
        step();

        // Reset after two accepts.
        send(4'd3); send(4'd4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", int'(bz[0]), 0);
        check("midrst_valid", int'(ov[0]), 0);
        step(); step();
        check("midrst_no_valid", int'(ov[0]), 0);

        // COUNT=1 instance: one operand completes the frame.
        iv[1] = 1'b1; ia[1] = 4'd9;
        step();
        iv[1] = 1'b0;
        check("c1_valid", int'(ov[1]), 1);
        check("c1_outS", int'(os[1]), 9);
        check("c1_cout", int'(co[1]), 0);
        step();
        check("c1_after", int'(ov[1]), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
